// File: rtl/add_matrix_sequencer.sv
// add_matrix_sequencer: computes an N x M element-wise matrix sum row by row through one
// shared add_vector. Operands are buffered on accept, results are collected in issue order.
module add_matrix_sequencer #(
  parameter int    BITS        = 16,
  parameter string PRECISION   = "HALF",
  parameter int    N           = 3,
  parameter int    M           = 2,
  parameter int    MAX_LATENCY = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a [N][M],
  input  logic [BITS-1:0] b [N][M],
  output logic            out_valid,
  output logic [BITS-1:0] c [N][M],
  output logic            busy,
  output logic            error,
  output logic            vec_in_valid,
  output logic [BITS-1:0] vec_a [M],
  output logic [BITS-1:0] vec_b [M],
  input  logic            vec_out_valid,
  input  logic [BITS-1:0] vec_c [M]
);

  localparam int CW = $clog2(N + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;

  localparam logic [CW-1:0] ROWS       = CW'(N);
  localparam logic [CW-1:0] LAST_ROW   = CW'(N - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(MAX_LATENCY - 1);

  // PRECISION is a matching tag only; the data path never interprets the elements.
  if (PRECISION == "") begin : g_untagged
  end

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_issue_cnt;
  logic [CW-1:0]   w_issue_cnt_next;
  logic [CW-1:0]   r_coll_cnt;
  logic [CW-1:0]   w_coll_cnt_next;
  logic [FW-1:0]   r_flush_cnt;
  logic [FW-1:0]   w_flush_cnt_next;
  logic [BITS-1:0] r_a_buf   [N][M];
  logic [BITS-1:0] r_b_buf   [N][M];
  logic [BITS-1:0] r_res_buf [N][M];
  logic [BITS-1:0] w_res_next [N][M];
  logic [BITS-1:0] r_c       [N][M];
  logic            r_error;
  logic            w_capture;
  logic            w_coll_wr;
  logic            w_err_set;
  logic            w_load_c;
  logic [RW-1:0]   w_issue_row;
  logic [RW-1:0]   w_coll_row;

  assign w_issue_row = RW'(r_issue_cnt);
  assign w_coll_row  = RW'(r_coll_cnt);

  always_comb begin
    w_state_next     = r_state;
    w_issue_cnt_next = r_issue_cnt;
    w_coll_cnt_next  = r_coll_cnt;
    w_flush_cnt_next = r_flush_cnt;
    w_capture        = 1'b0;
    w_coll_wr        = 1'b0;
    w_err_set        = 1'b0;
    vec_in_valid     = 1'b0;
    out_valid        = 1'b0;

    // Results are only expected while a transfer is in flight; FLUSH drops them silently.
    if (vec_out_valid) begin
      if ((r_state == S_ISSUE || r_state == S_WAIT) && (r_coll_cnt != ROWS)) begin
        w_coll_wr       = 1'b1;
        w_coll_cnt_next = r_coll_cnt + 1'b1;
      end else if (r_state != S_FLUSH) begin
        w_err_set = 1'b1;
      end
    end

    case (r_state)
      S_FLUSH: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_state_next     = S_IDLE;
          w_flush_cnt_next = '0;
        end else begin
          w_flush_cnt_next = r_flush_cnt + 1'b1;
        end
      end
      S_IDLE: begin
        if (in_valid) begin
          w_capture        = 1'b1;
          w_issue_cnt_next = '0;
          w_coll_cnt_next  = '0;
          w_state_next     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        vec_in_valid     = 1'b1;
        w_issue_cnt_next = r_issue_cnt + 1'b1;
        if (r_issue_cnt == LAST_ROW) begin
          w_state_next = (w_coll_cnt_next == ROWS) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_coll_cnt_next == ROWS) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_FLUSH;
      end
    endcase
  end

  // The row arriving on the DONE-entry edge must land in c together with the earlier rows.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < M; gj++) begin : g_col
      assign w_res_next[gi][gj] = (w_coll_wr && (w_coll_row == RW'(gi))) ?
                                  vec_c[gj] : r_res_buf[gi][gj];
    end
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_lane
    assign vec_a[gi] = r_a_buf[w_issue_row][gi];
    assign vec_b[gi] = r_b_buf[w_issue_row][gi];
  end

  assign w_load_c = (w_state_next == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FLUSH;
      r_issue_cnt <= '0;
      r_coll_cnt  <= '0;
      r_flush_cnt <= '0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_issue_cnt <= w_issue_cnt_next;
      r_coll_cnt  <= w_coll_cnt_next;
      r_flush_cnt <= w_flush_cnt_next;
      r_error     <= r_error | w_err_set;
    end
  end

  always_ff @(posedge clk) begin
    r_res_buf <= w_res_next;
    if (w_capture) begin
      r_a_buf <= a;
      r_b_buf <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c <= '{default: '0};
    end else if (w_load_c) begin
      r_c <= w_res_next;
    end
  end

  assign c        = r_c;
  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign error    = r_error;

endmodule

// File: tb/tb_add_matrix_sequencer.sv
// Directed bench for add_matrix_sequencer with a 3-cycle per-lane integer-add stub adder.
module tb_add_matrix_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a [3][2];
  logic [15:0] b [3][2];
  logic        out_valid;
  logic [15:0] c [3][2];
  logic        busy;
  logic        error;
  logic        vec_in_valid;
  logic [15:0] vec_a [2];
  logic [15:0] vec_b [2];
  logic        vec_out_valid;
  logic [15:0] vec_c [2];
  logic        spur;

  int n_vec  = 0;
  int n_fail = 0;

  logic [15:0] A1 [3][2] = '{'{16'd1, 16'd2}, '{16'd3, 16'd4}, '{16'd5, 16'd6}};
  logic [15:0] B1 [3][2] = '{'{16'd10, 16'd20}, '{16'd30, 16'd40}, '{16'd50, 16'd60}};
  logic [15:0] R1 [3][2] = '{'{16'd11, 16'd22}, '{16'd33, 16'd44}, '{16'd55, 16'd66}};
  logic [15:0] A2 [3][2] = '{default: 16'h3C00};
  logic [15:0] B2 [3][2] = '{default: 16'h4000};
  logic [15:0] R2 [3][2] = '{default: 16'h7C00};
  logic [15:0] A3 [3][2] = '{'{16'd7, 16'd8}, '{16'd9, 16'd100}, '{16'd1000, 16'd2}};
  logic [15:0] B3 [3][2] = '{'{16'd1, 16'd2}, '{16'd3, 16'd4}, '{16'd5, 16'hFFFF}};
  logic [15:0] R3 [3][2] = '{'{16'd8, 16'd10}, '{16'd12, 16'd104}, '{16'd1005, 16'd1}};

  always #5 clk = ~clk;

  // Stub add_vector: fixed latency 3, per-lane wrapping integer add.
  logic [2:0]  stub_v = 3'b000;
  logic [15:0] stub_c [3][2];
  always @(posedge clk) begin
    stub_v <= {stub_v[1:0], vec_in_valid};
    for (int j = 0; j < 2; j++) stub_c[0][j] <= vec_a[j] + vec_b[j];
    stub_c[1] <= stub_c[0];
    stub_c[2] <= stub_c[1];
  end
  assign vec_out_valid = stub_v[2] | spur;
  assign vec_c         = stub_c[2];

  add_matrix_sequencer #(
    .BITS(16), .PRECISION("HALF"), .N(3), .M(2), .MAX_LATENCY(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .busy(busy), .error(error),
    .vec_in_valid(vec_in_valid), .vec_a(vec_a), .vec_b(vec_b),
    .vec_out_valid(vec_out_valid), .vec_c(vec_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] vin_mask;
  logic [16:0] ov_mask;
  logic [16:0] rdy_mask;
  logic        stable_ok;
  logic [15:0] c_or;
  logic [63:0] row_exp;
  int          k;
  int          n_ov;
  int          k_ov;
  int          r;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    spur     = 1'b0;
    a        = A1;
    b        = B1;
    repeat (3) tick();

    // Reset values
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_vec_in_valid", 64'(vec_in_valid), 64'd0);
    c_or = '0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) c_or = c_or | c[i][j];
    chk("rst_c_zero", 64'(c_or), 64'd0);

    // Post-reset flush length
    reset = 1'b0;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    chk("flush_len", 64'(k), 64'd8);

    // Basic transfer followed by a back-to-back second matrix
    a = A1; b = B1; in_valid = 1'b1;
    vin_mask = '0; ov_mask = '0; rdy_mask = '0; stable_ok = 1'b1;
    for (int kk = 1; kk <= 16; kk++) begin
      tick();
      vin_mask[kk] = vec_in_valid;
      ov_mask[kk]  = out_valid;
      rdy_mask[kk] = in_ready;
      if (vec_in_valid && (kk <= 3 || (kk >= 9 && kk <= 11))) begin
        if (kk <= 3) begin
          r = kk - 1;
          row_exp = {A1[r][0], A1[r][1], B1[r][0], B1[r][1]};
        end else begin
          r = kk - 9;
          row_exp = {A2[r][0], A2[r][1], B2[r][0], B2[r][1]};
        end
        chk($sformatf("issue_row_c%0d", kk), {vec_a[0], vec_a[1], vec_b[0], vec_b[1]}, row_exp);
      end
      if (kk == 7) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 2; j++)
            chk($sformatf("c1[%0d][%0d]", i, j), 64'(c[i][j]), 64'(R1[i][j]));
      end
      if (kk >= 8 && kk <= 14) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 2; j++)
            if (c[i][j] !== R1[i][j]) stable_ok = 1'b0;
      end
      if (kk == 15) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 2; j++)
            chk($sformatf("c2[%0d][%0d]", i, j), 64'(c[i][j]), 64'(R2[i][j]));
      end
      if (kk == 1) begin
        a = A2;
        b = B2;
      end
      if (kk == 9) in_valid = 1'b0;
    end
    chk("vin_cycles", 64'(vin_mask), 64'h0_0E0E);
    chk("out_valid_cycles", 64'(ov_mask), 64'h0_8080);
    chk("in_ready_cycles", 64'(rdy_mask), 64'h1_0100);
    chk("c1_stable", 64'(stable_ok), 64'd1);
    chk("b2b_error", 64'(error), 64'd0);

    // Reset in cycle 2 of a transfer
    a = A1; b = B1; in_valid = 1'b1;
    chk("ready_before_rst", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("busy_in_flush", 64'(busy), 64'd1);
    n_ov = 0;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
      if (out_valid) n_ov++;
    end
    chk("rst_ready_delay", 64'(k), 64'd8);
    chk("rst_no_out_valid", 64'(n_ov), 64'd0);
    chk("rst_flush_error", 64'(error), 64'd0);

    // Spurious result in IDLE, then a good transfer
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk("spur_error_set", 64'(error), 64'd1);
    a = A3; b = B3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 30) begin
      tick();
      k++;
    end
    chk("spur_xfer_latency", 64'(k), 64'd6);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("c3[%0d][%0d]", i, j), 64'(c[i][j]), 64'(R3[i][j]));
    chk("error_sticky", 64'(error), 64'd1);
    tick();

    // in_valid pulsed during ISSUE with different data must be ignored
    a = A1; b = B1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    a = A2; b = B2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_ov = 0;
    k_ov = 0;
    for (int kk = 4; kk <= 15; kk++) begin
      tick();
      if (out_valid) begin
        n_ov++;
        k_ov = kk;
      end
    end
    chk("gate_out_valid_count", 64'(n_ov), 64'd1);
    chk("gate_out_valid_cycle", 64'(k_ov), 64'd7);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        chk($sformatf("c_gate[%0d][%0d]", i, j), 64'(c[i][j]), 64'(R1[i][j]));

    // Only reset clears the sticky error
    reset = 1'b1;
    tick();
    chk("error_cleared_by_reset", 64'(error), 64'd0);
    reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
